// File: rtl/sine_gen_pkg.sv
// ---------------------------------------------------------------------------
// sine_gen_pkg
// Shared definitions for the sine generator: output shaping mode encodings,
// frequency-shift clamp limits, the default peak amplitude and a helper that
// clamps a requested shift into the range the oscillator can tolerate.
// ---------------------------------------------------------------------------
package sine_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BIPOLAR   = 2'd0,  // two's-complement sample
    MODE_OFFSET    = 2'd1,  // offset-binary (MSB inverted)
    MODE_FULL_RECT = 2'd2,  // absolute value
    MODE_HALF_RECT = 2'd3   // negative half forced to zero
  } mode_e;

  // Smallest legal shift; the largest is W - K_MAX_MARGIN.
  localparam logic [3:0] K_MIN        = 4'd1;
  localparam int unsigned K_MAX_MARGIN = 2;

  localparam logic [15:0] AMP_DEFAULT = 16'h7530;

  // Clamp a requested shift into K_MIN .. w-K_MAX_MARGIN. The upper limit is
  // also capped at 15 since the shift port is only four bits wide.
  function automatic logic [3:0] clamp_k(input logic [3:0] k, input int unsigned w);
    int unsigned k_max;
    k_max = w - K_MAX_MARGIN;
    if (k_max > 32'd15) k_max = 32'd15;
    if (k < K_MIN)
      return K_MIN;
    else if (32'(k) > k_max)
      return 4'(k_max);
    else
      return k;
  endfunction

endpackage

// File: rtl/sine_gen_wave_shaper.sv
// ---------------------------------------------------------------------------
// wave_shaper
// Purely combinational output shaping for one oscillator channel.
//   sample_i [OW-1:0]  signed two's-complement sample (top bits of the state)
//   mode_i   [1:0]     shaping mode, encoded as sine_gen_pkg::mode_e
//   shaped_o [OW-1:0]  shaped sample
// ---------------------------------------------------------------------------
module wave_shaper
  import sine_gen_pkg::*;
#(
  parameter int OW = 8
) (
  input  logic [OW-1:0] sample_i,
  input  logic [1:0]    mode_i,
  output logic [OW-1:0] shaped_o
);

  localparam logic [OW-1:0] MOST_NEG = {1'b1, {(OW-1){1'b0}}};
  localparam logic [OW-1:0] MOST_POS = {1'b0, {(OW-1){1'b1}}};

  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    shaped_o = sample_i;
    case (mode_e'(mode_i))
      MODE_BIPOLAR:   shaped_o = sample_i;
      MODE_OFFSET:    shaped_o = {~sample_i[OW-1], sample_i[OW-2:0]};
      MODE_FULL_RECT: begin
        // The most-negative code has no positive counterpart; saturate it.
        if (sample_i == MOST_NEG)
          shaped_o = MOST_POS;
        else if (sample_i[OW-1])
          shaped_o = -sample_i;
      end
      MODE_HALF_RECT: begin
        if (sample_i[OW-1]) shaped_o = '0;
      end
      default: shaped_o = sample_i;
    endcase
  end

endmodule

// File: rtl/sine_gen_param.sv
// ---------------------------------------------------------------------------
// sine_gen_param
// Parameterised sine oscillator built on the coupled "magic circle"
// recurrence: sin += cos >>> k; cos -= sin_new >>> k. One oscillator step is
// taken every div+1 enabled cycles; each step produces a registered, shaped
// output sample with a one-cycle valid pulse, and a zc pulse on the step where
// the sine crosses zero going upwards. The shift k only takes effect at such
// a crossing so frequency changes never produce a phase glitch.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (overrides en)
//   en        run enable; low freezes all state
//   div[DW]   sample-rate divider
//   k[4]      frequency shift, clamped to 1..W-2 when latched
//   mode[2]   output shaping mode (see sine_gen_pkg::mode_e)
//   wave[OW]  shaped sine sample, registered
//   valid     one-cycle pulse when wave updates
//   zc        one-cycle pulse on a rising zero crossing of the sine
//   cos_wave  shaped cosine sample (only with SINE_GEN_COS_OUT_EN defined)
//
// Build option: define SINE_GEN_COS_OUT_EN to add the cos_wave output.
// ---------------------------------------------------------------------------
module sine_gen_param
  import sine_gen_pkg::*;
#(
  parameter int          W   = 16,
  parameter int          OW  = 8,
  parameter logic [W-1:0] AMP = W'(AMP_DEFAULT),
  parameter int          DW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] div,
  input  logic [3:0]    k,
  input  logic [1:0]    mode,
  output logic [OW-1:0] wave,
  output logic          valid,
  output logic          zc
`ifdef SINE_GEN_COS_OUT_EN
  ,
  output logic [OW-1:0] cos_wave
`endif
);

  logic signed [W-1:0] sin_q, sin_d;
  logic signed [W-1:0] cos_q, cos_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [3:0]          k_q, k_d;
  logic [OW-1:0]       wave_q, wave_d;
  logic                valid_q;
  logic                zc_q;
  logic                tick;
  logic                rise_zc;

  always_comb begin
    tick  = en && (div_cnt_q == div);
    // Arithmetic shifts and natural W-bit wrap; the cosine uses the freshly
    // updated sine, which keeps the recurrence stable.
    sin_d = sin_q + (cos_q >>> k_q);
    cos_d = cos_q - (sin_d >>> k_q);
    rise_zc = tick && sin_q[W-1] && !sin_d[W-1];

    div_cnt_d = div_cnt_q;
    if (en) begin
      // A divider lowered below the running count restarts the count.
      if (tick || (div_cnt_q > div))
        div_cnt_d = '0;
      else
        div_cnt_d = div_cnt_q + DW'(1);
    end

    k_d = rise_zc ? clamp_k(k, W) : k_q;
  end

  wave_shaper #(.OW(OW)) u_sin_shaper (
    .sample_i (sin_d[W-1 -: OW]),
    .mode_i   (mode),
    .shaped_o (wave_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_q     <= '0;
      cos_q     <= AMP;
      div_cnt_q <= '0;
      k_q       <= clamp_k(k, W);
      wave_q    <= '0;
      valid_q   <= 1'b0;
      zc_q      <= 1'b0;
    end else begin
      valid_q   <= tick;
      zc_q      <= rise_zc;
      div_cnt_q <= div_cnt_d;
      k_q       <= k_d;
      if (tick) begin
        sin_q  <= sin_d;
        cos_q  <= cos_d;
        wave_q <= wave_d;
      end
    end
  end

  assign wave  = wave_q;
  assign valid = valid_q;
  assign zc    = zc_q;

`ifdef SINE_GEN_COS_OUT_EN
  logic [OW-1:0] cos_wave_q, cos_wave_d;

  wave_shaper #(.OW(OW)) u_cos_shaper (
    .sample_i (cos_d[W-1 -: OW]),
    .mode_i   (mode),
    .shaped_o (cos_wave_d)
  );

  always_ff @(posedge clk) begin
    if (rst)
      cos_wave_q <= '0;
    else if (tick)
      cos_wave_q <= cos_wave_d;
  end

  assign cos_wave = cos_wave_q;
`endif

endmodule

// File: tb/tb_sine_gen_param.sv
// ---------------------------------------------------------------------------
// tb_sine_gen_param
// Self-checking bench for sine_gen_param (W=16, OW=8, DW=8). A reference
// model of the oscillator pushes the expected sample onto a queue on every
// step; the sample is popped and compared when the DUT raises valid. A table
// of hand-derived early samples plus directed sequences cover reset, divider,
// frequency change, shaping modes, enable freeze and mid-run reset.
// ---------------------------------------------------------------------------
module tb_sine_gen_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] div = 8'd0;
  logic [3:0] k   = 4'd6;
  logic [1:0] mode = 2'd0;
  logic [7:0] wave;
  logic       valid;
  logic       zc;
`ifdef SINE_GEN_COS_OUT_EN
  logic [7:0] cos_wave;
`endif

  always #5 clk = ~clk;

  sine_gen_param #(.W(16), .OW(8), .AMP(16'h7530), .DW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .div   (div),
    .k     (k),
    .mode  (mode),
    .wave  (wave),
    .valid (valid),
    .zc    (zc)
`ifdef SINE_GEN_COS_OUT_EN
    ,
    .cos_wave (cos_wave)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [7:0] wave;
    logic       zc;
  } exp_t;

  exp_t               sb_q[$];
  logic signed [15:0] m_sin, m_cos, m_nsin, m_ncos;
  logic [7:0]         m_cnt;
  logic [3:0]         m_k;
  logic               m_exp_valid = 1'b0;

  function automatic logic [3:0] ref_clamp(input logic [3:0] kk);
    if (kk == 4'd0) return 4'd1;
    if (kk > 4'd14) return 4'd14;
    return kk;
  endfunction

  function automatic logic [7:0] ref_shape(input logic [7:0] s, input logic [1:0] md);
    int sv;
    sv = int'($signed(s));
    case (md)
      2'd0: return s;
      2'd1: return s ^ 8'h80;
      2'd2: begin
        if (sv == -128) return 8'h7F;
        if (sv < 0) return 8'(-sv);
        return s;
      end
      default: return (sv < 0) ? 8'h00 : s;
    endcase
  endfunction

  task automatic model_and_check();
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_sin = '0;
        m_cos = 16'h7530;
        m_cnt = '0;
        m_k   = ref_clamp(k);
        m_exp_valid = 1'b0;
        sb_q.delete();
      end else begin
        m_exp_valid = 1'b0;
        if (en) begin
          if (m_cnt == div) begin
            m_nsin = m_sin + (m_cos >>> m_k);
            m_ncos = m_cos - (m_nsin >>> m_k);
            e.wave = ref_shape(m_nsin[15:8], mode);
            e.zc   = m_sin[15] && !m_nsin[15];
            if (e.zc) m_k = ref_clamp(k);
            sb_q.push_back(e);
            m_sin = m_nsin;
            m_cos = m_ncos;
            m_cnt = '0;
            m_exp_valid = 1'b1;
          end else if (m_cnt > div) begin
            m_cnt = '0;
          end else begin
            m_cnt = m_cnt + 8'd1;
          end
        end
      end
      @(negedge clk);
      check("sb_valid", 32'(valid), 32'(m_exp_valid));
      if (valid) begin
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check("sb_wave", 32'(wave), 32'(got.wave));
          check("sb_zc", 32'(zc), 32'(got.zc));
        end
      end else begin
        check("sb_zc_idle", 32'(zc), 0);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input logic [3:0] kk, input logic [1:0] md, input logic [7:0] dv);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; k = kk; mode = md; div = dv;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
  endtask

  // Counts steps (valid pulses) up to and including the next zc pulse.
  task automatic ticks_to_zc(input int budget, output int ticks, output int cycles);
    ticks = 0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (valid) ticks++;
    end while (!zc && cycles < budget);
    if (!zc) ticks = -1;
  endtask

  typedef struct {
    logic [3:0] k;
    logic [1:0] mode;
    int         n;      // which sample after reset
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, cycles, cnt, bad, last, zeros, maxv;
    fork
      model_and_check();
    join_none

    // Sample values derived by hand from the recurrence (AMP = 0x7530).
    vecs[0]  = '{4'd6, 2'd0, 1, 8'h01};
    vecs[1]  = '{4'd6, 2'd1, 1, 8'h81};
    vecs[2]  = '{4'd1, 2'd0, 1, 8'h3A};
    vecs[3]  = '{4'd1, 2'd0, 2, 8'h66};
    vecs[4]  = '{4'd1, 2'd0, 3, 8'h78};
    vecs[5]  = '{4'd1, 2'd1, 3, 8'hF8};
    vecs[6]  = '{4'd1, 2'd0, 7, 8'hD1};
    vecs[7]  = '{4'd1, 2'd1, 7, 8'h51};
    vecs[8]  = '{4'd1, 2'd2, 7, 8'h2F};
    vecs[9]  = '{4'd1, 2'd3, 7, 8'h00};
    vecs[10] = '{4'd0, 2'd0, 1, 8'h3A};   // k=0 clamps to 1

    // Reset state.
    do_reset(4'd6, 2'd0, 8'd0);
    en = 1'b0;
    check("rst_wave", 32'(wave), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_zc", 32'(zc), 0);
    check("rst_sin", 32'($unsigned(dut.sin_q)), 0);
    check("rst_cos", 32'($unsigned(dut.cos_q)), 32'h7530);

    // Table of early samples.
    for (int i = 0; i < 11; i++) begin
      do_reset(vecs[i].k, vecs[i].mode, 8'd0);
      cnt = 0;
      cycles = 0;
      while (cnt < vecs[i].n && cycles < 50) begin
        @(negedge clk);
        cycles++;
        if (valid) cnt++;
      end
      check($sformatf("vec%0d_wave", i), 32'(wave), 32'(vecs[i].exp));
    end

    // k=6, div=0: first step, valid every cycle, period.
    do_reset(4'd6, 2'd0, 8'd0);
    @(negedge clk);
    check("first_sin", 32'($unsigned(dut.sin_q)), 32'h01D4);
    check("first_wave", 32'(wave), 32'h01);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid) cnt++;
    end
    check("div0_valid_rate", cnt, 50);
    ticks_to_zc(1000, ticks, cycles);
    check_range("div0_first_zc", ticks, 1, 404);
    ticks_to_zc(1000, ticks, cycles);
    check_range("div0_zc_ticks", ticks, 400, 404);

    // div=3: one valid every 4 cycles, period 4x longer in cycles.
    do_reset(4'd6, 2'd0, 8'd3);
    cnt = 0; bad = 0; last = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid) begin
        if (last >= 0 && (i - last) != 4) bad++;
        last = i;
        cnt++;
      end
    end
    check("div3_valid_count", cnt, 100);
    check("div3_valid_gaps", bad, 0);
    ticks_to_zc(4000, ticks, cycles);
    check_range("div3_first_zc", ticks, 1, 404);
    ticks_to_zc(4000, ticks, cycles);
    check_range("div3_zc_ticks", ticks, 400, 404);
    check_range("div3_zc_cycles", cycles, 1600, 1616);

    // Divider lowered below the running count clears it.
    do_reset(4'd6, 2'd0, 8'd7);
    repeat (5) @(negedge clk);
    div = 8'd2;
    @(negedge clk);
    check("div_lower_clear", 32'(dut.div_cnt_q), 0);
    repeat (10) @(negedge clk);

    // k 6 -> 5 mid-period: current period unchanged, next one halves.
    do_reset(4'd6, 2'd0, 8'd0);
    ticks_to_zc(1000, ticks, cycles);
    check_range("kchg_first_zc", ticks, 1, 404);
    ticks = 0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (valid) ticks++;
      if (ticks == 100) k = 4'd5;
    end while (!zc && cycles < 1000);
    if (!zc) ticks = -1;
    check_range("kchg_old_period", ticks, 400, 404);
    ticks_to_zc(1000, ticks, cycles);
    check_range("kchg_new_period", ticks, 199, 203);

    // Modes 2 and 3 over a full period.
    do_reset(4'd6, 2'd2, 8'd0);
    bad = 0; maxv = 0;
    for (int i = 0; i < 410; i++) begin
      @(negedge clk);
      if (valid) begin
        if (wave > 8'h7F) bad++;
        if (int'(wave) > maxv) maxv = int'(wave);
      end
    end
    check("mode2_range", bad, 0);
    check_range("mode2_peak", maxv, 8'h70, 8'h7F);
    mode = 2'd3;
    bad = 0; zeros = 0;
    for (int i = 0; i < 402; i++) begin
      @(negedge clk);
      if (valid) begin
        if (wave[7]) bad++;
        if (wave == 8'h00) zeros++;
      end
    end
    check("mode3_no_neg", bad, 0);
    check_range("mode3_zero_half", zeros, 195, 215);

    // Enable low freezes state, then reset overrides a running oscillator.
    mode = 2'd0;
    repeat (37) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(valid), 0);
      check("hold_sin", 32'($unsigned(dut.sin_q)), 32'($unsigned(m_sin)));
      check("hold_cos", 32'($unsigned(dut.cos_q)), 32'($unsigned(m_cos)));
      check("hold_k", 32'(dut.k_q), 32'(m_k));
    end
    en = 1'b1;
    rst = 1'b1;
    k = 4'd15;
    @(negedge clk);
    check("mid_rst_sin", 32'($unsigned(dut.sin_q)), 0);
    check("mid_rst_cos", 32'($unsigned(dut.cos_q)), 32'h7530);
    check("mid_rst_wave", 32'(wave), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_zc", 32'(zc), 0);
    check("mid_rst_k_clamp", 32'(dut.k_q), 14);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
